// File: rtl/estagio_decodificacao.sv
// -----------------------------------------------------------------------------
// estagio_decodificacao
//   IF/ID pipeline register plus instruction decode for the MIPS32 core.
//   A single holding slot latches the fetched instruction and its PC+4. The
//   register-bank read addresses (rs/rt/rd) and all ID/EX decode outputs are
//   derived combinationally from that slot. A load-use hazard against the
//   instruction currently in EX holds the slot and withholds out_valid.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake carrying in_instr and in_pc4
//   flush                 taken branch/jump in EX: drop held and incoming instr
//   ex_mem_read, ex_rt    load currently in EX and its destination register
//   rs, rt, rd            register fields of the held instruction
//   out_valid/out_ready   ID/EX handshake
//   out_*                 decoded fields, immediates, jump target, control bits
//   hazard_stall          load-use stall active this cycle
// -----------------------------------------------------------------------------
module estagio_decodificacao #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc4,
  output logic              in_ready,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [4:0]        out_shamt,
  output logic [DATA_W-1:0] out_imm_sext,
  output logic [DATA_W-1:0] out_imm_zext,
  output logic [DATA_W-1:0] out_jump_tgt,
  output logic [DATA_W-1:0] out_pc4,
  output logic [4:0]        out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              hazard_stall
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t       held_state;
  slot_state_t       held_state_next;
  logic [31:0]       held_instr;
  logic [31:0]       held_instr_next;
  logic [DATA_W-1:0] held_pc4;
  logic [DATA_W-1:0] held_pc4_next;

  logic        held_valid;
  logic [31:0] eff_instr;
  logic        uses_rs;
  logic        uses_rt;
  logic        hazard;
  logic        fire;
  logic        load;
  logic        reg_write_raw;

  assign held_valid = (held_state == FULL);

  // An empty slot decodes as NOP_INSTR, so stale contents left after a
  // consume never leak onto the read ports or the control bits.
  assign eff_instr = held_valid ? held_instr : NOP_INSTR;

  assign out_opcode   = eff_instr[31:26];
  assign rs           = eff_instr[25:21];
  assign rt           = eff_instr[20:16];
  assign rd           = eff_instr[15:11];
  assign out_shamt    = eff_instr[10:6];
  assign out_funct    = eff_instr[5:0];
  assign out_imm_sext = {{(DATA_W-16){eff_instr[15]}}, eff_instr[15:0]};
  assign out_imm_zext = {{(DATA_W-16){1'b0}}, eff_instr[15:0]};
  assign out_jump_tgt = {held_pc4[DATA_W-1 -: 4], eff_instr[25:0], 2'b00};
  assign out_pc4      = held_pc4;

  // Operand usage: j/jal read no register, shifts by shamt ignore rs; rt is a
  // source only for R-type, beq/bne and sw.
  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (out_opcode)
      6'h00: begin
        uses_rs = !((out_funct == 6'h00) || (out_funct == 6'h02) || (out_funct == 6'h03));
        uses_rt = 1'b1;
      end
      6'h02, 6'h03: begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
      6'h04, 6'h05, 6'h2B: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      default: begin
        uses_rs = 1'b1;
        uses_rt = 1'b0;
      end
    endcase
  end

  // Destination register and raw register-write enable by opcode.
  always_comb begin
    out_dest      = rt;
    reg_write_raw = 1'b0;
    case (out_opcode)
      6'h00: begin
        out_dest      = rd;
        reg_write_raw = (out_funct != 6'h08);
      end
      6'h03: begin
        out_dest      = 5'd31;
        reg_write_raw = 1'b1;
      end
      6'h23, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        out_dest      = rt;
        reg_write_raw = 1'b1;
      end
      default: begin
        out_dest      = rt;
        reg_write_raw = 1'b0;
      end
    endcase
  end

  // Writes to $0 are suppressed here so later stages never see them.
  assign out_reg_write = held_valid & reg_write_raw & (out_dest != 5'd0);
  assign out_mem_read  = held_valid & (out_opcode == 6'h23);
  assign out_mem_write = held_valid & (out_opcode == 6'h2B);

  // The stall lasts exactly as long as EX keeps presenting the load.
  assign hazard = held_valid & ex_mem_read & (ex_rt != 5'd0) &
                  ((uses_rs & (rs == ex_rt)) | (uses_rt & (rt == ex_rt)));

  assign hazard_stall = hazard;
  assign out_valid    = held_valid & ~hazard;
  assign fire         = out_valid & out_ready;
  // Fire and load may happen together, keeping throughput at one per cycle.
  assign in_ready     = ~reset & (~held_valid | fire);
  assign load         = in_valid & in_ready;

  // Slot next-state: flush beats load, load beats consume, otherwise hold.
  always_comb begin
    held_state_next = held_state;
    held_instr_next = held_instr;
    held_pc4_next   = held_pc4;
    if (flush) begin
      held_state_next = EMPTY;
      held_instr_next = NOP_INSTR;
    end else if (load) begin
      held_state_next = FULL;
      held_instr_next = in_instr;
      held_pc4_next   = in_pc4;
    end else if (fire) begin
      held_state_next = EMPTY;
    end else begin
      held_state_next = held_state;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_state <= EMPTY;
      held_instr <= NOP_INSTR;
      held_pc4   <= {DATA_W{1'b0}};
    end else begin
      held_state <= held_state_next;
      held_instr <= held_instr_next;
      held_pc4   <= held_pc4_next;
    end
  end

endmodule

// File: tb/tb_estagio_decodificacao.sv
// -----------------------------------------------------------------------------
// tb_estagio_decodificacao
//   Directed scenarios followed by randomized traffic. The driver keeps a
//   one-slot reference model and pushes the expected decode of every accepted
//   instruction into a scoreboard queue; the monitor pops and compares on each
//   DUT output handshake and checks the handshake/stall flags every cycle.
// -----------------------------------------------------------------------------
module tb_estagio_decodificacao;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0000_0000;
  logic [31:0] in_pc4 = 32'h0000_0000;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic [4:0]  rs, rt, rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_shamt;
  logic [31:0] out_imm_sext, out_imm_zext, out_jump_tgt, out_pc4;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_mem_read, out_mem_write, hazard_stall;

  estagio_decodificacao #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc4(in_pc4), .in_ready(in_ready), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_funct(out_funct), .out_shamt(out_shamt), .out_imm_sext(out_imm_sext),
    .out_imm_zext(out_imm_zext), .out_jump_tgt(out_jump_tgt), .out_pc4(out_pc4),
    .out_dest(out_dest), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .hazard_stall(hazard_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  dest;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] jt;
    logic [31:0] pc4;
    logic        rw;
    logic        mr;
    logic        mw;
  } dec_t;

  dec_t        exp_q[$];
  bit          m_held = 1'b0;
  logic [31:0] m_instr = 32'h0000_0000;
  bit          exp_ready = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_haz = 1'b0;
  bit          exp_held = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic int unsigned fld(input logic [31:0] w, input int lsb, input int nb);
    return int'((w >> lsb) & ((32'd1 << nb) - 32'd1));
  endfunction

  function automatic bit uses_rs_f(input logic [31:0] i);
    int unsigned op = fld(i, 26, 6);
    int unsigned fn = fld(i, 0, 6);
    return !(op == 2 || op == 3) && !(op == 0 && (fn == 0 || fn == 2 || fn == 3));
  endfunction

  function automatic bit uses_rt_f(input logic [31:0] i);
    int unsigned op = fld(i, 26, 6);
    return (op == 0 || op == 4 || op == 5 || op == 43);
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] p4);
    dec_t r;
    int unsigned op  = fld(i, 26, 6);
    int unsigned fn  = fld(i, 0, 6);
    int unsigned s   = fld(i, 21, 5);
    int unsigned t   = fld(i, 16, 5);
    int unsigned d   = fld(i, 11, 5);
    int unsigned imm = fld(i, 0, 16);
    int unsigned dst = (op == 0) ? d : ((op == 3) ? 31 : t);
    bit wr = (op == 0 && fn != 8) ||
             (op == 35 || op == 8 || op == 9 || op == 10 || op == 12 || op == 13 ||
              op == 15 || op == 3);
    r.opcode = 6'(op);
    r.funct  = 6'(fn);
    r.shamt  = 5'(fld(i, 6, 5));
    r.rs     = 5'(s);
    r.rt     = 5'(t);
    r.rd     = 5'(d);
    r.dest   = 5'(dst);
    r.zext   = imm;
    r.sext   = (imm >= 32768) ? (imm + 32'hFFFF_0000) : imm;
    r.jt     = (p4 & 32'hF000_0000) | (fld(i, 0, 26) * 4);
    r.pc4    = p4;
    r.rw     = wr && (dst != 0);
    r.mr     = (op == 35);
    r.mw     = (op == 43);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge and advance the reference model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p4,
                      input bit ordy, input bit fl, input bit emr, input logic [4:0] ert);
    bit haz, fire, acc;
    @(posedge clock);
    #1;
    reset = 1'b0; in_valid = v; in_instr = ins; in_pc4 = p4;
    out_ready = ordy; flush = fl; ex_mem_read = emr; ex_rt = ert;
    haz = m_held && emr && (ert != 5'd0) &&
          ((uses_rs_f(m_instr) && fld(m_instr, 21, 5) == ert) ||
           (uses_rt_f(m_instr) && fld(m_instr, 16, 5) == ert));
    exp_held  = m_held;
    exp_haz   = haz;
    exp_valid = m_held && !haz;
    fire      = exp_valid && ordy;
    exp_ready = !m_held || fire;
    acc       = v && exp_ready && !fl;
    if (fl) begin
      if (m_held && !fire) void'(exp_q.pop_front());
      m_held = 1'b0;
    end else if (acc) begin
      exp_q.push_back(ref_decode(ins, p4));
      m_held  = 1'b1;
      m_instr = ins;
    end else if (fire) begin
      m_held = 1'b0;
    end
  endtask

  // Monitor: handshake flags every cycle, scoreboard pop on each output handshake.
  always @(negedge clock) begin
    dec_t e;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("hazard_stall", 32'(hazard_stall), 32'(exp_haz));
    if (!exp_held) begin
      chk("idle_rs", 32'(rs), 32'd0);
      chk("idle_rd", 32'(rd), 32'd0);
      chk("idle_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("opcode", 32'(out_opcode), 32'(e.opcode));
        chk("funct", 32'(out_funct), 32'(e.funct));
        chk("shamt", 32'(out_shamt), 32'(e.shamt));
        chk("rs", 32'(rs), 32'(e.rs));
        chk("rt", 32'(rt), 32'(e.rt));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("imm_sext", out_imm_sext, e.sext);
        chk("imm_zext", out_imm_zext, e.zext);
        chk("jump_tgt", out_jump_tgt, e.jt);
        chk("pc4", out_pc4, e.pc4);
        chk("dest", 32'(out_dest), 32'(e.dest));
        chk("reg_write", 32'(out_reg_write), 32'(e.rw));
        chk("mem_read", 32'(out_mem_read), 32'(e.mr));
        chk("mem_write", 32'(out_mem_write), 32'(e.mw));
      end
    end
  end

  logic [5:0] ops[13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                          6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fns[6]  = '{6'h20, 6'h08, 6'h00, 6'h02, 6'h03, 6'h2A};

  initial begin
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh;
    logic [15:0] imm;
    logic [31:0] ins;

    // Reset held for two cycles with fetch offering an instruction.
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      reset = 1'b1; in_valid = 1'b1; in_instr = 32'h012A_4020; out_ready = 1'b0;
      flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
      m_held = 1'b0; exp_held = 1'b0; exp_ready = 1'b0; exp_valid = 1'b0; exp_haz = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("rst_rs", 32'(rs), 32'd0);
      chk("rst_rt", 32'(rt), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
    end

    // add $8,$9,$10 accepted on the first cycle out of reset.
    step(1'b1, 32'h012A_4020, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    chk("t2_rs", 32'(rs), 32'd9);
    chk("t2_rt", 32'(rt), 32'd10);
    chk("t2_rd", 32'(rd), 32'd8);
    chk("t2_dest", 32'(out_dest), 32'd8);
    chk("t2_reg_write", 32'(out_reg_write), 32'd1);

    // Load-use hazard on rs, then non-matching ex_rt and ex_rt=0.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
    @(negedge clock);
    chk("t4_rs_stable", 32'(rs), 32'd9);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd11);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);

    // Back-pressure for three cycles, then fire and load together.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h2008_FFFB, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clock);
      chk("t5_rd_stable", 32'(rd), 32'd8);
    end
    step(1'b1, 32'h2008_FFFB, 32'h0040_0008, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    chk("t3_imm_sext", out_imm_sext, 32'hFFFF_FFFB);
    chk("t3_imm_zext", out_imm_zext, 32'h0000_FFFB);
    chk("t3_dest", 32'(out_dest), 32'd8);
    chk("t3_mem_read", 32'(out_mem_read), 32'd0);

    // jal, then flush with an incoming instruction that must be dropped.
    step(1'b1, 32'h0C00_0010, 32'h4000_0004, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    chk("t6_jump_tgt", out_jump_tgt, 32'h4000_0040);
    chk("t6_dest", 32'(out_dest), 32'd31);
    chk("t6_reg_write", 32'(out_reg_write), 32'd1);
    step(1'b1, 32'h012A_4020, 32'h4000_0008, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    chk("t6_flush_opcode", 32'(out_opcode), 32'd0);
    chk("t6_flush_rt", 32'(rt), 32'd0);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      op  = ops[$urandom_range(0, 12)];
      fn  = fns[$urandom_range(0, 5)];
      s   = 5'($urandom_range(0, 3));
      t   = 5'($urandom_range(0, 3));
      d   = 5'($urandom_range(0, 3));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      if (op == 6'h00)
        ins = {op, s, t, d, sh, fn};
      else if (op == 6'h02 || op == 6'h03)
        ins = {op, 26'($urandom)};
      else
        ins = {op, s, t, imm};
      step(($urandom_range(0, 9) < 7), ins, ($urandom & 32'hFFFF_FFFC),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)));
    end

    // Drain the slot and confirm every accepted instruction was seen.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
